// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider sizing and FSM state encoding.
// Imported by the sequential divider and its trial subtractor.
package arith_pkg;

    localparam int DIV_WIDTH = 20;
    localparam int DIV_CNT_W = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_FIN  = ST_FIN
    } div_state_e;

    // Quotient reported for a zero divisor: every bit set.
    function automatic logic [DIV_WIDTH-1:0] div_zero_quotient();
        return {DIV_WIDTH{1'b1}};
    endfunction

endpackage : arith_pkg

// File: rtl/seq_restoring_divider_trial_subtractor.sv
// Combinational (WIDTH+1)-bit trial subtraction for one restoring-divide step.
// Borrow set means the shifted partial remainder is smaller than the divisor.
module trial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rs,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] t_s;

    // Single subtract; the top bit of the wrapped result is the borrow.
    always_comb begin
        t_s    = rs - {1'b0, divisor};
        diff   = t_s[WIDTH-1:0];
        borrow = t_s[WIDTH];
    end

endmodule : trial_subtractor

// File: rtl/seq_restoring_divider.sv
// Unsigned sequential restoring divider, one trial subtraction per clock.
// Start/done handshake, one operation in flight, registered results.
module seq_restoring_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   rs_s;
    logic [WIDTH-1:0] diff_s;
    logic             borrow_s;

    // Partial remainder shifted left, pulling in the next dividend bit.
    always_comb begin
        rs_s = {r_q, q_q[WIDTH-1]};
    end

    trial_subtractor #(.WIDTH(WIDTH)) u_trial_sub (
        .rs      (rs_s),
        .divisor (divisor_q),
        .diff    (diff_s),
        .borrow  (borrow_s)
    );

    // Next-state, iteration datapath and result loading.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        r_d         = r_q;
        q_d         = q_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dividend_d = dividend;
                    divisor_d  = divisor;
                    if (divisor == {WIDTH{1'b0}}) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RUN;
                        count_d = {CNT_W{1'b0}};
                        r_d     = {WIDTH{1'b0}};
                        q_d     = dividend;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (borrow_s) begin
                    r_d = rs_s[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end else begin
                    r_d = diff_s;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = S_FIN;
                    quotient_d  = q_d;
                    remainder_d = r_d;
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIN: begin
                // Entering FIN without done means a zero divisor: publish now.
                if (done_q) begin
                    state_d = S_IDLE;
                end else begin
                    quotient_d  = div_zero_quotient();
                    remainder_d = dividend_q;
                    dbz_d       = 1'b1;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, working and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= {CNT_W{1'b0}};
            r_q         <= {WIDTH{1'b0}};
            q_q         <= {WIDTH{1'b0}};
            dividend_q  <= {WIDTH{1'b0}};
            divisor_q   <= {WIDTH{1'b0}};
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            r_q         <= r_d;
            q_q         <= q_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule : seq_restoring_divider

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider against a plain / and % reference.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seq_restoring_divider;

    localparam int W = 20;
    localparam logic [W-1:0] ALL1 = 20'hFFFFF;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks;
    int failures;

    seq_restoring_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one cycle; returns in cycle 1 after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom;
    endtask

    // Advance until done is seen or the budget expires; cyc is the cycle index.
    task automatic wait_done(input int from_cyc, output int cyc);
        cyc = from_cyc;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_result(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq, er;
        logic         ez;
        if (b == '0) begin eq = ALL1; er = a; ez = 1'b1; end
        else         begin eq = a / b; er = a % b; ez = 1'b0; end
        checks++;
        if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            failures++;
            $display("FAIL %s: %0d/%0d got q=%0d r=%0d dz=%0b expected q=%0d r=%0d dz=%0b",
                     name, a, b, quotient, remainder, div_by_zero, eq, er, ez);
        end
    endtask

    task automatic check_latency(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: done at cycle %0d expected cycle %0d", name, got, exp);
        end
    endtask

    task automatic check_done_single(input string name);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL %s: done=%0b one cycle after pulse expected 0", name, done);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL %s: busy=%0b done=%0b q=%0h r=%0h dz=%0b expected all 0",
                     name, busy, done, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        int cyc;
        issue(a, b);
        wait_done(1, cyc);
        check_latency(name, cyc, (b == '0) ? 2 : 21);
        check_result(name, a, b);
        check_done_single(name);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset_release");
    endtask

    task automatic test_basic();
        int cyc;
        issue(20'h00064, 20'h00007);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy: busy=%0b expected 1", busy);
        end
        wait_done(1, cyc);
        check_latency("basic_latency", cyc, 21);
        check_result("basic_100_7", 20'd100, 20'd7);
        check_done_single("basic_pulse");
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || quotient !== 20'd14 || remainder !== 20'd2) begin
            failures++;
            $display("FAIL basic_hold: busy=%0b q=%0d r=%0d expected busy=0 q=14 r=2", busy, quotient, remainder);
        end
    endtask

    task automatic test_boundaries();
        run_op("max_by_1", ALL1, 20'h00001);
        run_op("max_by_max", ALL1, ALL1);
        run_op("small_by_big", 20'd3, 20'd10);
        run_op("zero_dividend", 20'd0, 20'd17);
    endtask

    task automatic test_div_zero();
        run_op("div_zero", 20'd5, 20'd0);
        run_op("after_div_zero", 20'd9, 20'd3);
    endtask

    task automatic test_start_ignored();
        int cyc;
        int extra;
        issue(20'd100, 20'd7);
        repeat (7) @(negedge clk);
        start = 1'b1; dividend = 20'd50; divisor = 20'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(9, cyc);
        check_latency("ignored_latency", cyc, 21);
        check_result("ignored_result", 20'd100, 20'd7);
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL ignored_extra_done: %0d extra done pulses expected 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        issue(20'd1000, 20'd3);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort_immediate");
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_done: %0d done pulses expected 0", seen);
        end
        run_op("after_abort", 20'd1000, 20'd3);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] as [0:20];
        logic [W-1:0] bs [0:20];
        int cyc;
        for (int i = 0; i < 21; i++) begin
            as[i] = W'($urandom);
            case (i % 3)
                0:       bs[i] = W'($urandom_range(1, 20'hFFFFF));
                1:       bs[i] = W'($urandom_range(1, 15));
                default: bs[i] = W'($urandom_range(1, 1000));
            endcase
        end
        start = 1'b1; dividend = as[0]; divisor = bs[0];
        @(negedge clk);
        dividend = as[1]; divisor = bs[1];
        for (int i = 0; i < 20; i++) begin
            wait_done(1, cyc);
            check_latency($sformatf("b2b_period_%0d", i), cyc + ((i == 0) ? 0 : 1), (i == 0) ? 21 : 22);
            check_result($sformatf("b2b_op_%0d", i), as[i], bs[i]);
            @(negedge clk);
            @(negedge clk);
            dividend = as[i + 2 > 20 ? 20 : i + 2];
            divisor  = bs[i + 2 > 20 ? 20 : i + 2];
        end
        start = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_restoring_divider
